// File: rtl/dcache_refill_if.sv
// dcache_refill_if: miss request, memory read port and tag/data RAM write signals of dcache_refill
interface dcache_refill_if;
  logic        tag_init_done;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ack;
  logic        busy;
  logic        refill_done;
  logic        refill_err;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;
  logic        tag_en;
  logic [3:0]  tag_wen;
  logic [6:0]  tag_index;
  logic [20:0] tag_wdata;
  logic        data_wen;
  logic [6:0]  data_index;
  logic [2:0]  data_word;
  logic [31:0] data_wdata;
  modport master(
    input  tag_init_done, miss_req, miss_addr, mem_rd_ready, mem_rvalid, mem_rdata, mem_rlast,
    output miss_ack, busy, refill_done, refill_err, crit_valid, crit_data, mem_rd_req, mem_rd_addr,
           tag_en, tag_wen, tag_index, tag_wdata, data_wen, data_index, data_word, data_wdata
  );
  modport slave(
    output tag_init_done, miss_req, miss_addr, mem_rd_ready, mem_rvalid, mem_rdata, mem_rlast,
    input  miss_ack, busy, refill_done, refill_err, crit_valid, crit_data, mem_rd_req, mem_rd_addr,
           tag_en, tag_wen, tag_index, tag_wdata, data_wen, data_index, data_word, data_wdata
  );
endinterface

// File: rtl/dcache_refill.sv
// dcache_refill: 8-beat line refill into tag/data RAM; DCACHE_REFILL_CWF_EN selects critical-word-first bursts
module dcache_refill #(
  parameter int BURST_LEN  = 8,
  parameter int MEM_ADDR_W = 32
) (
  input logic           clk,
  input logic           resetn,
  dcache_refill_if.master bus
);
  typedef enum logic [2:0] {IDLE, INVAL, REQ, RECV, COMMIT} state_t;
  state_t                state;
  logic [MEM_ADDR_W-1:2] addr;
  logic [2:0]            cnt;
  logic [2:0]            seen;
  logic [2:0]            start;
  logic [31:0]           rd_addr;
  logic                  ack;
  logic                  beat;
`ifdef DCACHE_REFILL_CWF_EN
  assign start   = addr[4:2];
  assign rd_addr = {addr, 2'b00};
`else
  assign start   = 3'd0;
  assign rd_addr = {addr[MEM_ADDR_W-1:5], 5'b0};
`endif
  // request acceptance and beat write-through are combinational so ack and data land in the same cycle
  always_comb begin
    ack             = resetn && state == IDLE && bus.miss_req && bus.tag_init_done;
    beat            = resetn && state == RECV && bus.mem_rvalid;
    bus.miss_ack    = ack;
    bus.busy        = state != IDLE;
    bus.data_wen    = beat;
    bus.data_index  = beat ? addr[11:5] : 7'd0;
    bus.data_word   = beat ? cnt : 3'd0;
    bus.data_wdata  = beat ? bus.mem_rdata : 32'd0;
    bus.crit_valid  = beat && cnt == addr[4:2];
    bus.crit_data   = bus.crit_valid ? bus.mem_rdata : 32'd0;
  end
  // refill FSM; tag writes, burst request and completion pulses are registered on entry to each state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      addr            <= '0;
      cnt             <= '0;
      seen            <= '0;
      bus.tag_en      <= 1'b0;
      bus.tag_wen     <= 4'h0;
      bus.tag_index   <= 7'd0;
      bus.tag_wdata   <= 21'd0;
      bus.mem_rd_req  <= 1'b0;
      bus.mem_rd_addr <= 32'd0;
      bus.refill_done <= 1'b0;
      bus.refill_err  <= 1'b0;
    end else begin
      bus.tag_en      <= 1'b0;
      bus.tag_wen     <= 4'h0;
      bus.tag_index   <= 7'd0;
      bus.tag_wdata   <= 21'd0;
      bus.refill_done <= 1'b0;
      bus.refill_err  <= 1'b0;
      case (state)
        IDLE: if (ack) begin
          addr          <= bus.miss_addr[MEM_ADDR_W-1:2];
          bus.tag_en    <= 1'b1;
          bus.tag_wen   <= 4'hF;
          bus.tag_index <= bus.miss_addr[11:5];
          bus.tag_wdata <= {1'b0, bus.miss_addr[31:12]};
          state         <= INVAL;
        end
        INVAL: begin
          bus.mem_rd_req  <= 1'b1;
          bus.mem_rd_addr <= rd_addr;
          state           <= REQ;
        end
        REQ: if (bus.mem_rd_ready) begin
          bus.mem_rd_req  <= 1'b0;
          bus.mem_rd_addr <= 32'd0;
          cnt             <= start;
          seen            <= 3'd0;
          state           <= RECV;
        end
        RECV: if (bus.mem_rvalid) begin
          cnt  <= cnt + 3'd1;
          seen <= seen + 3'd1;
          if (seen == 3'(BURST_LEN - 1)) begin
            bus.tag_en      <= 1'b1;
            bus.tag_wen     <= 4'hF;
            bus.tag_index   <= addr[11:5];
            bus.tag_wdata   <= {1'b1, addr[31:12]};
            bus.refill_done <= 1'b1;
            state           <= COMMIT;
          end else if (bus.mem_rlast) begin
            bus.refill_err <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dcache_refill.md
Name: dcache_refill

Overview:
- Writer side of the dcache tag/data store.
- On a lookup miss, fetches one 32-byte line from memory as an 8-beat read burst and writes it into the data RAM one word per beat.
- Invalidates the tag entry before the burst and writes the valid tag only after the full line has arrived.
- Sits between the dcache miss logic and the memory read port. Line geometry: tag = addr[31:12], index = addr[11:5], word = addr[4:2]; tag entry = {valid, tag[19:0]} (21 bits).

Parameters:
- BURST_LEN, 8, beats per line (fixed to 8; other values unsupported).
- MEM_ADDR_W, 32, memory address width.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  reset. One clock; reset is synchronous and active-low.
- tag_init_done  in  1  tag store finished its power-on clear sweep; no refill accepted before it is 1.
- miss_req  in  1  miss pending (level).
- miss_addr  in  32  missing byte address.
- miss_ack  out  1  one-cycle pulse: request latched.
- busy  out  1  FSM not in IDLE.
- refill_done  out  1  one-cycle pulse: line valid in cache.
- refill_err  out  1  one-cycle pulse: short burst, line left invalid.
- crit_valid  out  1  one-cycle pulse: requested word available.
- crit_data  out  32  requested word, valid with crit_valid.
- mem_rd_req  out  1  burst request.
- mem_rd_addr  out  32  burst start address.
- mem_rd_ready  in  1  memory accepted request.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data.
- mem_rlast  in  1  final beat.
- tag_en  out  1  tag RAM enable.
- tag_wen  out  4  tag RAM write enable; 4'hF on write, else 0.
- tag_index  out  7  tag RAM index.
- tag_wdata  out  21  {valid, tag}.
- data_wen  out  1  data RAM word write.
- data_index  out  7  data RAM index.
- data_word  out  3  word within line.
- data_wdata  out  32  data RAM write data.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, beat counter=0, latched address=0. All outputs 0. Applies mid-burst too: the burst is abandoned, and memory beats after reset release are ignored until the next REQ.
- IDLE:
  - If miss_req && tag_init_done: latch miss_addr, pulse miss_ack, go to INVAL.
  - If miss_req && !tag_init_done: no ack; stay in IDLE.
- INVAL (1 cycle): tag_en=1, tag_wen=4'hF, tag_index=addr[11:5], tag_wdata={1'b0, addr[31:12]}. Next state is REQ.
- REQ:
  - mem_rd_req=1 and mem_rd_addr held stable until mem_rd_ready=1 in the same cycle.
  - On that cycle, go to RECV and load the beat counter with the start word.
- RECV, on each mem_rvalid:
  - data_wen=1, data_index=addr[11:5], data_word=counter, data_wdata=mem_rdata.
  - Counter increments modulo 8 (wraps 7→0); beats_seen increments.
  - If counter==addr[4:2]: crit_valid=1 and crit_data=mem_rdata in the same cycle (combinational from the beat).
  - 8th beat (beats_seen==7 on entry): go to COMMIT regardless of mem_rlast. Beats arriving after the 8th, before the next REQ, are ignored and not written.
  - mem_rlast before the 8th beat: that beat is still written, then pulse refill_err and return to IDLE. The tag stays invalid and refill_done is not pulsed.
- COMMIT (1 cycle): tag write with {1'b1, addr[31:12]}, pulse refill_done, go to IDLE. A new miss can be acked at the earliest in the cycle after COMMIT.
- miss_req while busy=1 is ignored and never acked.
- Latency with zero memory wait, miss_req high at cycle 0: miss_ack @0, INVAL write @1, mem_rd_req @2, beats @3..10, COMMIT/refill_done @11.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro DCACHE_REFILL_CWF_EN (critical word first).
- Defined: mem_rd_addr={addr[31:5], addr[4:2], 2'b00}; the counter starts at addr[4:2] and the burst wraps, so crit_valid comes on the first beat.
- Undefined: mem_rd_addr={addr[31:5], 5'b0}; the counter starts at 0 and crit_valid comes on beat addr[4:2].

Test Plan:
- tag_init_done=0, miss_req=1 for 20 cycles → no miss_ack, busy=0. Then tag_init_done=1 → miss_ack next cycle.
- miss_addr=0x1234_5A68, zero-wait memory returning 0xA0..0xA7, macro undefined → INVAL writes tag_wdata=0x012345 at index 0x53. mem_rd_addr=0x1234_5A60. Data words 0..7 written. crit_valid on beat 2 with crit_data=0xA2. Tag write 0x112345, refill_done at cycle 11.
- Same stimulus with DCACHE_REFILL_CWF_EN → mem_rd_addr=0x1234_5A68, write order 2,3,4,5,6,7,0,1, crit_valid on the first beat with 0xA2.
- mem_rlast asserted on beat 4 → 4 data writes, refill_err pulse, no valid tag write, busy=0 next cycle.
- resetn=0 during beat 3, then a second miss → all outputs 0 during reset. The second refill completes normally and stale beats are not written.
- mem_rd_ready held 0 for 5 cycles → mem_rd_req and mem_rd_addr stable throughout; a new miss_req during busy is not acked.
